mem_req_arbiter: RTL

- Shares the single cache port (instruction_read / mem_read / mem_write, one busy flag) between the instruction-fetch stage and the load/store stage.
- Accepts one request per requester and picks a winner: data has priority, with a bound on how long instruction fetch can be starved.
- Drives the cache command, tracks the cache busy handshake and returns the response to the winner.
- Sits between the pipeline front end / memory stage and the cache.

---
 rtl/mem_req_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mem_req_arbiter.sv
`timescale 1ns/1ps
// Shares one cache port between instruction fetch and load/store, one transaction at a time.
// Data wins arbitration unless fetch has already been passed over MAX_D_STREAK times in a row.
module mem_req_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int INST_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic              i_resp_valid,
  output logic [INST_W-1:0] i_resp,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_size,
  output logic              d_ack,
  output logic              d_resp_valid,
  output logic [DATA_W-1:0] d_resp,
  output logic              instruction_read,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] instruction_address,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        req_size,
  input  logic              cache_busy,
  input  logic [INST_W-1:0] instruction_response,
  input  logic [DATA_W-1:0] mem_response
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

  state_t            state_q;
  owner_t            owner_q;
  logic [SW-1:0]     streak_q;
  logic              we_q;
  logic              i_ack_q, d_ack_q, i_resp_valid_q, d_resp_valid_q;
  logic [INST_W-1:0] i_resp_q;
  logic [DATA_W-1:0] d_resp_q;
  logic              ird_q, mrd_q, mwr_q;
  logic [ADDR_W-1:0] iaddr_q, maddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        size_q;

  logic streak_max, grant_d;

  assign streak_max = (streak_q == SW'(MAX_D_STREAK));
  assign grant_d    = d_req && !(i_req && streak_max);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      owner_q        <= OWN_NONE;
      streak_q       <= '0;
      we_q           <= 1'b0;
      i_ack_q        <= 1'b0;
      d_ack_q        <= 1'b0;
      i_resp_valid_q <= 1'b0;
      d_resp_valid_q <= 1'b0;
      i_resp_q       <= '0;
      d_resp_q       <= '0;
      ird_q          <= 1'b0;
      mrd_q          <= 1'b0;
      mwr_q          <= 1'b0;
      iaddr_q        <= '0;
      maddr_q        <= '0;
      wdata_q        <= '0;
      size_q         <= '0;
    end else begin
      i_ack_q        <= 1'b0;
      d_ack_q        <= 1'b0;
      i_resp_valid_q <= 1'b0;
      d_resp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (i_req || d_req) begin
            state_q <= ISSUE;
            if (grant_d) begin
              owner_q <= OWN_D;
              we_q    <= d_we;
              d_ack_q <= 1'b1;
              mrd_q   <= !d_we;
              mwr_q   <= d_we;
              maddr_q <= d_addr;
              wdata_q <= d_wdata;
              size_q  <= d_size;
              // Streak only counts data grants that actually passed over a waiting fetch.
              if (!i_req)
                streak_q <= '0;
              else if (!streak_max)
                streak_q <= streak_q + SW'(1);
            end else begin
              owner_q  <= OWN_I;
              i_ack_q  <= 1'b1;
              ird_q    <= 1'b1;
              iaddr_q  <= i_addr;
              size_q   <= 4'(INST_W / 8);
              streak_q <= '0;
            end
          end
        end
        ISSUE: begin
          if (cache_busy) begin
            ird_q   <= 1'b0;
            mrd_q   <= 1'b0;
            mwr_q   <= 1'b0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (!cache_busy) begin
            if (owner_q == OWN_I) begin
              i_resp_q       <= instruction_response;
              i_resp_valid_q <= 1'b1;
            end else begin
              d_resp_q       <= we_q ? '0 : mem_response;
              d_resp_valid_q <= 1'b1;
            end
            state_q <= RESP;
          end
        end
        RESP: begin
          owner_q <= OWN_NONE;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign i_ack               = i_ack_q;
  assign d_ack               = d_ack_q;
  assign i_resp_valid        = i_resp_valid_q;
  assign d_resp_valid        = d_resp_valid_q;
  assign i_resp              = i_resp_q;
  assign d_resp              = d_resp_q;
  assign instruction_read    = ird_q;
  assign mem_read            = mrd_q;
  assign mem_write           = mwr_q;
  assign instruction_address = iaddr_q;
  assign mem_address         = maddr_q;
  assign mem_wdata           = wdata_q;
  assign req_size            = size_q;

  a_cmd_onehot: assert property (@(posedge clk) disable iff (reset)
    $onehot0({instruction_read, mem_read, mem_write}));

endmodule
